// File: rtl/moore_pattern_gen.sv
// Moore serial pattern transmitter: sends PATTERN MSB-first on X with VALID, optional repeats; macro PATTERN_GEN_PARITY_EN adds an even-parity bit per frame.
// First bit two cycles after START is accepted; START is ignored while BUSY (no backpressure on X).
module moore_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 4,
    parameter int RW    = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] PATTERN,
    input  logic [CNTW-1:0]  LEN,
    input  logic [RW-1:0]    REPEAT,
    output logic             X,
    output logic             VALID,
    output logic             BUSY,
    output logic             DONE,
    output logic [15:0]      EDGES,
    output logic [2:0]       Cstate
);

    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        LOAD  = 3'b001,
        SHIFT = 3'b011,
        PAR   = 3'b111,
        GAP   = 3'b010,
        FIN   = 3'b110
    } state_t;

    localparam logic [CNTW-1:0] LEN_MAX = CNTW'(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] pat_cap;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] frame_init;
    logic [CNTW-1:0]  len_cap;
    logic [CNTW-1:0]  bitcnt;
    logic [CNTW-1:0]  len_in;
    logic [RW-1:0]    rep_cap;
    logic [RW-1:0]    rep_left;
    logic             prev_x;
    logic             first_bit;
    logic             edge_hit;

    assign len_in     = (LEN > LEN_MAX) ? LEN_MAX : LEN;
    // Left-justify the frame so its first bit sits in the MSB of the shifter.
    assign frame_init = pat_cap << (WIDTH - int'(len_cap));
    assign edge_hit   = !first_bit && (X != prev_x) && (EDGES != 16'hFFFF);
    assign Cstate     = state;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            X         <= 1'b0;
            VALID     <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            EDGES     <= 16'd0;
            pat_cap   <= '0;
            shreg     <= '0;
            len_cap   <= '0;
            bitcnt    <= '0;
            rep_cap   <= '0;
            rep_left  <= '0;
            prev_x    <= 1'b0;
            first_bit <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    X     <= 1'b0;
                    VALID <= 1'b0;
                    DONE  <= 1'b0;
                    if (START && (LEN != '0)) begin
                        pat_cap <= PATTERN;
                        len_cap <= len_in;
                        rep_cap <= REPEAT;
                        EDGES   <= 16'd0;
                        BUSY    <= 1'b1;
                        state   <= LOAD;
                    end else begin
                        BUSY <= 1'b0;
                    end
                end
                LOAD: begin
                    shreg     <= frame_init;
                    bitcnt    <= len_cap;
                    rep_left  <= rep_cap;
                    X         <= frame_init[WIDTH-1];
                    VALID     <= 1'b1;
                    first_bit <= 1'b1;
                    state     <= SHIFT;
                end
                SHIFT: begin
                    shreg     <= shreg << 1;
                    bitcnt    <= bitcnt - CNTW'(1);
                    prev_x    <= X;
                    first_bit <= 1'b0;
                    if (edge_hit)
                        EDGES <= EDGES + 16'd1;
                    if (bitcnt == CNTW'(1)) begin
`ifdef PATTERN_GEN_PARITY_EN
                        X     <= ^frame_init;
                        VALID <= 1'b1;
                        state <= PAR;
`else
                        X     <= 1'b0;
                        VALID <= 1'b0;
                        if (rep_left != '0) begin
                            state <= GAP;
                        end else begin
                            DONE  <= 1'b1;
                            state <= FIN;
                        end
`endif
                    end else begin
                        X <= shreg[WIDTH-2];
                    end
                end
`ifdef PATTERN_GEN_PARITY_EN
                PAR: begin
                    prev_x <= X;
                    X      <= 1'b0;
                    VALID  <= 1'b0;
                    if (edge_hit)
                        EDGES <= EDGES + 16'd1;
                    if (rep_left != '0) begin
                        state <= GAP;
                    end else begin
                        DONE  <= 1'b1;
                        state <= FIN;
                    end
                end
`endif
                GAP: begin
                    shreg     <= frame_init;
                    bitcnt    <= len_cap;
                    rep_left  <= rep_left - RW'(1);
                    X         <= frame_init[WIDTH-1];
                    VALID     <= 1'b1;
                    first_bit <= 1'b1;
                    state     <= SHIFT;
                end
                FIN: begin
                    X     <= 1'b0;
                    VALID <= 1'b0;
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    X     <= 1'b0;
                    VALID <= 1'b0;
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_moore_pattern_gen.sv
// Bench for moore_pattern_gen: table vectors, corner sequences and random frames against a frame-level model.
module tb_moore_pattern_gen;

`ifdef PATTERN_GEN_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [7:0]  PATTERN;
    logic [3:0]  LEN;
    logic [3:0]  REPEAT;
    logic        X;
    logic        VALID;
    logic        BUSY;
    logic        DONE;
    logic [15:0] EDGES;
    logic [2:0]  Cstate;

    int          checks = 0;
    int          errors = 0;
    logic [3:0]  exp_q[$];
    int          exp_edges;
    int          last_edges;
    int          done_off;
    logic [31:0] obs_bits;

    typedef struct {
        logic [7:0]  pat;
        logic [3:0]  len;
        logic [3:0]  rep;
        logic [31:0] bits;
        int          edges;
        int          done_at;
    } vec_t;

    vec_t tbl[4];

    moore_pattern_gen #(.WIDTH(8), .CNTW(4), .RW(4)) dut (
        .CLK(CLK), .RST(RST), .START(START), .PATTERN(PATTERN), .LEN(LEN),
        .REPEAT(REPEAT), .X(X), .VALID(VALID), .BUSY(BUSY), .DONE(DONE),
        .EDGES(EDGES), .Cstate(Cstate)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected per-cycle {X,VALID,BUSY,DONE} from the cycle after acceptance through FIN.
    task automatic model(input logic [7:0] pat, input logic [3:0] len, input logic [3:0] rep);
        int n;
        int per;
        bit p;
        bit fb[$];
        n = (len > 4'd8) ? 8 : int'(len);
        fb.delete();
        for (int i = n - 1; i >= 0; i--) fb.push_back(pat[i]);
        if (PAR_EN) begin
            p = 1'b0;
            foreach (fb[k]) p ^= fb[k];
            fb.push_back(p);
        end
        per = 0;
        for (int k = 1; k < fb.size(); k++)
            if (fb[k] != fb[k-1]) per++;
        exp_edges = per * (int'(rep) + 1);
        if (exp_edges > 65535) exp_edges = 65535;
        exp_q.delete();
        exp_q.push_back(4'b0010);
        for (int f = 0; f <= int'(rep); f++) begin
            foreach (fb[k]) exp_q.push_back({fb[k], 3'b110});
            if (f < int'(rep)) exp_q.push_back(4'b0010);
        end
        exp_q.push_back(4'b0011);
    endtask

    task automatic run_txn(input logic [7:0] pat, input logic [3:0] len,
                           input logic [3:0] rep, input bit hold);
        model(pat, len, rep);
        PATTERN  = pat;
        LEN      = len;
        REPEAT   = rep;
        START    = 1'b1;
        done_off = 0;
        obs_bits = 32'd0;
        for (int k = 0; k < exp_q.size(); k++) begin
            step();
            if (k == 0) begin
                chk("load_state", {29'd0, Cstate}, 32'd1);
                if (!hold) begin
                    START   = 1'b0;
                    PATTERN = 8'($urandom);
                    LEN     = 4'($urandom);
                    REPEAT  = 4'($urandom);
                end
            end
            chk($sformatf("cycle%0d_xvbd", k + 1), {28'd0, X, VALID, BUSY, DONE}, {28'd0, exp_q[k]});
            if (VALID) obs_bits = {obs_bits[30:0], X};
            if (DONE && done_off == 0) done_off = k + 1;
        end
        step();
        chk("idle_after", {25'd0, X, VALID, BUSY, DONE, Cstate}, 32'd0);
        chk("edges", {16'd0, EDGES}, exp_edges);
        last_edges = exp_edges;
    endtask

    initial begin
`ifdef PATTERN_GEN_PARITY_EN
        tbl[0] = '{8'hB2, 4'd8,  4'd0, 32'h164, 5, 11};
        tbl[1] = '{8'h05, 4'd3,  4'd2, 32'hAAA, 9, 16};
        tbl[2] = '{8'hA5, 4'd12, 4'd0, 32'h14A, 7, 11};
        tbl[3] = '{8'h07, 4'd3,  4'd0, 32'h00F, 0, 6};
`else
        tbl[0] = '{8'hB2, 4'd8,  4'd0, 32'h0B2, 5, 10};
        tbl[1] = '{8'h05, 4'd3,  4'd2, 32'h16D, 6, 13};
        tbl[2] = '{8'hA5, 4'd12, 4'd0, 32'h0A5, 6, 10};
        tbl[3] = '{8'h07, 4'd3,  4'd0, 32'h007, 0, 5};
`endif
        RST = 1'b1; START = 1'b0; PATTERN = 8'd0; LEN = 4'd0; REPEAT = 4'd0;
        last_edges = 0;
        step();
        step();
        chk("reset_outs", {25'd0, X, VALID, BUSY, DONE, Cstate}, 32'd0);
        chk("reset_edges", {16'd0, EDGES}, 32'd0);
        RST = 1'b0;
        step();
        chk("idle_start", {25'd0, X, VALID, BUSY, DONE, Cstate}, 32'd0);

        foreach (tbl[i]) begin
            run_txn(tbl[i].pat, tbl[i].len, tbl[i].rep, 1'b0);
            chk($sformatf("tbl%0d_bits", i), obs_bits, tbl[i].bits);
            chk($sformatf("tbl%0d_done_at", i), done_off, tbl[i].done_at);
            chk($sformatf("tbl%0d_edges", i), {16'd0, EDGES}, tbl[i].edges);
        end

        // LEN=0 must not start anything nor disturb EDGES.
        START = 1'b1; LEN = 4'd0; PATTERN = 8'hFF; REPEAT = 4'd1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("len0_quiet", {27'd0, VALID, BUSY, Cstate}, 32'd0);
            chk("len0_edges", {16'd0, EDGES}, last_edges);
        end
        START = 1'b0;
        step();

        // START held high: second transaction accepted only once back in IDLE.
        run_txn(8'hB2, 4'd8, 4'd0, 1'b1);
        step();
        chk("hold_reaccept", {31'd0, BUSY}, 32'd1);
        START = 1'b0;
        for (int n = 0; n < 40 && BUSY; n++) step();
        chk("hold_finished", {31'd0, BUSY}, 32'd0);
        model(8'hB2, 4'd8, 4'd0);
        chk("hold_edges", {16'd0, EDGES}, exp_edges);

        // Reset during the third SHIFT cycle, then a clean frame.
        PATTERN = 8'hB2; LEN = 4'd8; REPEAT = 4'd0; START = 1'b1;
        step();
        START = 1'b0;
        step();
        step();
        step();
        chk("pre_reset_valid", {31'd0, VALID}, 32'd1);
        RST = 1'b1;
        step();
        chk("midreset_outs", {25'd0, X, VALID, BUSY, DONE, Cstate}, 32'd0);
        chk("midreset_edges", {16'd0, EDGES}, 32'd0);
        RST = 1'b0;
        run_txn(8'hB2, 4'd8, 4'd0, 1'b0);
        chk("post_reset_bits", obs_bits, tbl[0].bits);

        for (int r = 0; r < 25; r++)
            run_txn(8'($urandom), 4'($urandom_range(1, 15)), 4'($urandom_range(0, 3)), 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/moore_pattern_gen.md
Name: moore_pattern_gen

Overview:
- Moore-style serial pattern transmitter; the sending end of the single-bit X stream that the team's sequence detectors consume.
- Loads a programmed bit pattern on a START request and shifts it out MSB-first on X, one bit per CLK, with VALID qualifying each bit.
- Optionally repeats the frame.
- Reports BUSY/DONE status and counts the bit transitions emitted, so the bench can cross-check the detector's Z pulse count.

Parameters:
- WIDTH, 8, maximum frame length in bits.
- CNTW, 4, width of LEN and of the internal bit counter; must satisfy 2^CNTW > WIDTH.
- RW, 4, width of REPEAT; frames sent = REPEAT+1.

Ports:
- CLK  input  1  clock; all logic on posedge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  request; sampled only in IDLE.
- PATTERN  input  WIDTH  frame bits; bit LEN-1 is sent first.
- LEN  input  CNTW  frame length; 0 = invalid, values > WIDTH are clamped to WIDTH.
- REPEAT  input  RW  extra frame count.
- X  output  1  serial data.
- VALID  output  1  X carries a frame bit this cycle.
- BUSY  output  1  transaction in progress.
- DONE  output  1  one-cycle pulse at transaction end.
- EDGES  output  16  transitions emitted in the current or last transaction.
- Cstate  output  3  current state, for debug.

Behaviour:
- Single clock, CLK. Reset is synchronous and active-high on RST.
- State encoding: IDLE=000, LOAD=001, SHIFT=011, PAR=111, GAP=010, FIN=110. Any other code goes to IDLE next cycle.
- Reset (RST=1 at a posedge): Cstate=IDLE, X=0, VALID=0, BUSY=0, DONE=0, EDGES=0; shift register, counters and captured inputs cleared. Reset wins over every other event, including mid-frame.
- IDLE: BUSY=0. START=1 with LEN!=0:
  - capture PATTERN, min(LEN,WIDTH) and REPEAT;
  - clear EDGES;
  - next state LOAD.
  START with LEN=0 is ignored.
- LOAD (1 cycle): shreg <= PATTERN_cap << (WIDTH-len_cap); bitcnt <= len_cap; rep_left <= REPEAT_cap; next state SHIFT.
- SHIFT: X=shreg[WIDTH-1], VALID=1. Each cycle: shreg shifts left by 1 and bitcnt decrements. When bitcnt==1, next state is PAR if the feature is enabled; otherwise GAP if rep_left!=0, else FIN.
- GAP (1 cycle): VALID=0, X=0; rep_left decrements; shreg and bitcnt reload from the captured values; next state SHIFT.
- FIN (1 cycle): DONE=1, BUSY=1; next state IDLE.
- BUSY=1 in every state except IDLE. X=0 whenever VALID=0.
- Latency: START accepted at edge t gives LOAD in cycle t+1 and the first bit in cycle t+2. Frame pitch is len+1 cycles. DONE occurs one cycle after the last bit.
- START while BUSY is ignored; captured values are unaffected by input changes after acceptance.
- EDGES increments when X differs from the previous VALID bit of the same frame. The first bit of a frame never counts. EDGES saturates at 16'hFFFF.
- Outputs are pure functions of registered state (Moore); no START-to-output combinational path.

Optional Feature:
- Macro PATTERN_GEN_PARITY_EN.
- Defined: PAR state after the last bit of each frame; X = even parity over the len_cap frame bits, VALID=1. The parity bit counts toward EDGES. Next state is GAP or FIN by the same rule as SHIFT. Frame pitch becomes len+2.
- Undefined: PAR is unreachable and is not synthesised; no parity bit is sent.

Test Plan:
- PATTERN=8'b1011_0010, LEN=8, REPEAT=0, START at t -> X=1,0,1,1,0,0,1,0 with VALID in t+2..t+9; DONE only at t+10; EDGES=5; BUSY t+1..t+10.
- PATTERN=8'b0000_0101, LEN=3, REPEAT=2 -> bits 1,0,1 at t+2..4, t+6..8 and t+10..12; VALID=0, X=0 at t+5 and t+9; DONE at t+13; EDGES=6.
- START held high throughout -> first transaction as above, next accepted only after return to IDLE. LEN=0 with START -> BUSY stays 0, no VALID, EDGES unchanged.
- RST=1 during the third SHIFT cycle -> next cycle all outputs are zero and Cstate=000. A fresh START then produces a correct full frame.
- LEN=4'd12, WIDTH=8, PATTERN=8'hA5 -> clamped to 8 bits: 1,0,1,0,0,1,0,1; EDGES=6.
- With PATTERN_GEN_PARITY_EN, PATTERN=8'b0000_0111, LEN=3 -> X=1,1,1,1 (parity 1) at t+2..t+5; DONE at t+6; EDGES=0.
